// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - round-robin scheduler granting one requester at a time to a serial transmitter
// Optional SEND watchdog enabled by defining TX_SCHED_TIMEOUT_EN.
module tx_scheduler #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              timeout,
    output logic              busy,
    output logic              transmitEnable,
    output logic              load,
    output logic [7:0]        parallelDataOut,
    input  logic              characterSent
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, GAP} state_t;

    state_t          state, stateNext;
    logic [PW-1:0]   ptr, ptrNext, owner, ownerNext, pick, idx;
    logic            found;
    logic [NREQ-1:0] grantNext, doneNext;
    logic            timeoutNext, busyNext, teNext, loadNext;
    logic [7:0]      pdoNext;
    logic [7:0]      chars [NREQ];

`ifdef TX_SCHED_TIMEOUT_EN
    logic [7:0] wdCount, wdCountNext;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_char
        assign chars[i] = data_in[8*i +: 8];
    end

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
    endfunction

    // Scan ascending from ptr with wraparound; first active request wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k >= NREQ) ? PW'(int'(ptr) + k - NREQ) : PW'(int'(ptr) + k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        ownerNext   = owner;
        grantNext   = grant;
        doneNext    = '0;
        timeoutNext = 1'b0;
        teNext      = 1'b0;
        loadNext    = 1'b0;
        pdoNext     = parallelDataOut;
`ifdef TX_SCHED_TIMEOUT_EN
        wdCountNext = wdCount;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    stateNext = LOAD;
                    ownerNext = pick;
                    grantNext = NREQ'(1) << pick;
                    teNext    = 1'b1;
                    loadNext  = 1'b1;
                    pdoNext   = chars[pick];
                end
            end
            LOAD: begin
                stateNext = SEND;
                teNext    = 1'b1;
`ifdef TX_SCHED_TIMEOUT_EN
                wdCountNext = '0;
`endif
            end
            SEND: begin
                teNext = 1'b1;
                if (characterSent) begin
                    stateNext = DONE;
                    grantNext = '0;
                    doneNext  = grant;
                    teNext    = 1'b0;
                    ptrNext   = incPtr(owner);
                end
`ifdef TX_SCHED_TIMEOUT_EN
                else if (wdCount == 8'(TIMEOUT_CYCLES - 1)) begin
                    stateNext   = GAP;
                    grantNext   = '0;
                    timeoutNext = 1'b1;
                    teNext      = 1'b0;
                    ptrNext     = incPtr(owner);
                end else begin
                    wdCountNext = wdCount + 8'd1;
                end
`endif
            end
            DONE:    stateNext = GAP;
            GAP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            owner           <= '0;
            grant           <= '0;
            done            <= '0;
            timeout         <= 1'b0;
            busy            <= 1'b0;
            transmitEnable  <= 1'b0;
            load            <= 1'b0;
            parallelDataOut <= '0;
        end else begin
            state           <= stateNext;
            ptr             <= ptrNext;
            owner           <= ownerNext;
            grant           <= grantNext;
            done            <= doneNext;
            timeout         <= timeoutNext;
            busy            <= busyNext;
            transmitEnable  <= teNext;
            load            <= loadNext;
            parallelDataOut <= pdoNext;
        end
    end

`ifdef TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wdCount <= '0;
        else       wdCount <= wdCountNext;
    end
`endif

endmodule

// File: tb/tb_tx_scheduler.sv
// tb/tb_tx_scheduler.sv - scoreboard bench for tx_scheduler (NREQ=4, TIMEOUT_CYCLES=20)
module tb_tx_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant, done;
    logic        timeout, busy, transmitEnable, load;
    logic [7:0]  parallelDataOut;
    logic        characterSent = 1'b0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t       expQ[$];
    int         vecCnt = 0;
    int         errCnt = 0;
    int         doneCount = 0;
    int         ackCnt = 0;
    int         ackDelay = 3;
    bit         ackOn = 1'b1;
    int         sinceDone = 0;
    bit         lastDoneValid = 1'b0;
    logic [3:0] lastGrant = '0;

    tx_scheduler #(.NREQ(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .grant(grant), .done(done), .timeout(timeout), .busy(busy),
        .transmitEnable(transmitEnable), .load(load),
        .parallelDataOut(parallelDataOut), .characterSent(characterSent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transmitter stand-in plus output monitor: pops the scoreboard on each load.
    always @(negedge clk) begin
        logic wasCs;
        exp_t e;
        if (reset) begin
            characterSent = 1'b0;
            ackCnt        = 0;
            sinceDone     = 0;
            lastDoneValid = 1'b0;
        end else begin
            wasCs = characterSent;
            characterSent = 1'b0;
            if (done != '0) begin
                doneCount++;
                chk("done_owner", 32'(done), 32'(lastGrant));
                chk("done_lat", 32'(wasCs), 32'(1));
                chk("done_grant0", 32'(grant), 32'(0));
                lastDoneValid = 1'b1;
                sinceDone     = 0;
            end else begin
                sinceDone++;
            end
            if (load) begin
                if (lastDoneValid) chk("b2b_gap", 32'(sinceDone >= 3), 32'(1));
                if (expQ.size() == 0) begin
                    chk("unexpected_load", 32'(grant), 32'(0));
                end else begin
                    e = expQ.pop_front();
                    chk("grant", 32'(grant), 32'(e.g));
                    chk("data", 32'(parallelDataOut), 32'(e.d));
                end
                lastGrant = grant;
                if (ackOn) ackCnt = ackDelay;
            end else if (ackCnt > 0) begin
                ackCnt--;
                if (ackCnt == 0) characterSent = 1'b1;
            end
        end
    end

    task automatic pushExp(input logic [3:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        expQ.push_back(e);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < maxCyc);
        if (done == '0) chk("wait_done_expired", 32'(0), 32'(1));
    endtask

    task automatic waitLoad(input int maxCyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load && n < maxCyc);
        if (!load) chk("wait_load_expired", 32'(0), 32'(1));
    endtask

    initial begin
        int snap;
        reset   = 1'b1;
        req     = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_te", 32'(transmitEnable), 32'(0));
        chk("rst_load", 32'(load), 32'(0));
        chk("rst_pdo", 32'(parallelDataOut), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // single request, ack 170 cycles after load, data changed after sampling
        data_in  = 32'h0000_0055;
        ackDelay = 170;
        req      = 4'b0001;
        pushExp(4'b0001, 8'h55);
        @(negedge clk);
        chk("lat_load", 32'(load), 32'(1));
        chk("lat_grant", 32'(grant), 32'(1));
        chk("lat_busy", 32'(busy), 32'(1));
        req     = '0;
        data_in = 32'h0000_00A5;
        @(negedge clk);
        chk("send_load_low", 32'(load), 32'(0));
        chk("send_te", 32'(transmitEnable), 32'(1));
        waitDone(400);
        chk("done_te", 32'(transmitEnable), 32'(0));
        @(negedge clk);
        chk("gap_busy", 32'(busy), 32'(1));
        chk("gap_te", 32'(transmitEnable), 32'(0));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_grant", 32'(grant), 32'(0));
        chk("idle_pdo_hold", 32'(parallelDataOut), 32'h55);

        // contention: all four requesting from ptr=0
        applyReset();
        data_in  = 32'h4433_2211;
        ackDelay = 3;
        pushExp(4'b0001, 8'h11);
        pushExp(4'b0010, 8'h22);
        pushExp(4'b0100, 8'h33);
        pushExp(4'b1000, 8'h44);
        pushExp(4'b0001, 8'h11);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            waitDone(100);
            if (i == 4) req = '0;
        end
        repeat (3) @(negedge clk);
        chk("cont_idle", 32'(busy), 32'(0));

        // fairness: req[2] joins while requester 0 is being served
        applyReset();
        ackDelay = 20;
        req = 4'b0001;
        pushExp(4'b0001, 8'h11);
        waitLoad(10);
        req = 4'b0101;
        pushExp(4'b0100, 8'h33);
        pushExp(4'b0001, 8'h11);
        for (int i = 0; i < 3; i++) begin
            waitDone(100);
            if (i == 2) req = '0;
        end
        repeat (3) @(negedge clk);

        // reset while in SEND
        applyReset();
        ackOn = 1'b0;
        req = 4'b0001;
        pushExp(4'b0001, 8'h11);
        waitLoad(10);
        req = '0;
        repeat (50) @(negedge clk);
        chk("pre_rst_te", 32'(transmitEnable), 32'(1));
        snap = doneCount;
        #2 reset = 1'b1;
        #1;
        chk("midrst_te", 32'(transmitEnable), 32'(0));
        chk("midrst_grant", 32'(grant), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_nodone", 32'(doneCount), 32'(snap));
        ackOn    = 1'b1;
        ackDelay = 5;
        req = 4'b0010;
        pushExp(4'b0010, 8'h22);
        waitLoad(10);
        req = '0;
        waitDone(100);
        repeat (3) @(negedge clk);

        // watchdog
        ackOn = 1'b0;
        req = 4'b1000;
        pushExp(4'b1000, 8'h44);
        waitLoad(10);
        req = '0;
`ifdef TX_SCHED_TIMEOUT_EN
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!timeout && n < 100);
            chk("wd_lat", 32'(n), 32'(21));
            chk("wd_grant", 32'(grant), 32'(0));
            chk("wd_done", 32'(done), 32'(0));
            chk("wd_te", 32'(transmitEnable), 32'(0));
            @(negedge clk);
            chk("wd_pulse_end", 32'(timeout), 32'(0));
            repeat (2) @(negedge clk);
            chk("wd_idle", 32'(busy), 32'(0));
        end
`else
        repeat (1000) @(negedge clk);
        chk("nowd_busy", 32'(busy), 32'(1));
        chk("nowd_te", 32'(transmitEnable), 32'(1));
        chk("nowd_grant", 32'(grant), 32'(4'b1000));
        chk("nowd_timeout", 32'(timeout), 32'(0));
        applyReset();
`endif
        ackOn = 1'b1;
        @(negedge clk);
        chk("done_total", 32'(doneCount), 32'(10));
        chk("sb_empty", 32'(expQ.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the SEND watchdog limit in clk cycles.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req, input, NREQ, per-requester request level.
REQ-006 The block SHALL have port data_in, input, 8*NREQ, packed characters; requester i at bits [8i+7:8i].
REQ-007 The block SHALL have port grant, output, NREQ, one-hot owner of the transmitter.
REQ-008 The block SHALL have port done, output, NREQ, one-cycle pulse when the owner's character is sent.
REQ-009 The block SHALL have port timeout, output, 1, one-cycle pulse on watchdog abort.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port transmitEnable, output, 1, enable to the serial transmitter.
REQ-012 The block SHALL have port load, output, 1, parallel-load strobe to the transmitter.
REQ-013 The block SHALL have port parallelDataOut, output, 8, character presented to the transmitter.
REQ-014 The block SHALL have port characterSent, input, 1, end-of-character indication from the transmitter.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE, LOAD, SEND, DONE and GAP.
REQ-017 IDLE with any req high: select the winner round-robin starting at index ptr, ascending, wrapping at NREQ; go to LOAD.
REQ-018 On the IDLE->LOAD edge: grant[winner]=1, parallelDataOut=data_in[winner] sampled that edge; data_in is not sampled again.
REQ-019 LOAD lasts exactly one cycle: transmitEnable=1, load=1; go to SEND.
REQ-020 SEND: transmitEnable=1, load=0; characterSent sampled high moves to DONE; characterSent during LOAD is ignored.
REQ-021 DONE lasts one cycle: done[winner]=1, grant=0, transmitEnable=0, ptr=(winner+1) mod NREQ; go to GAP.
REQ-022 GAP lasts one cycle with transmitEnable=0 so the transmitter counters re-arm; go to IDLE.
REQ-023 Latency: req high on edge t gives grant and load at t+1; a back-to-back next grant is possible no earlier than 3 cycles after DONE entry.
REQ-024 Deasserting req after grant SHALL NOT abort the transfer; req changes are ignored outside IDLE.
REQ-025 IDLE with no req: all strobes low, parallelDataOut holds its last value, ptr unchanged.
REQ-026 Simultaneous requests SHALL be served one at a time in round-robin order; no requester waits more than NREQ-1 transfers.
REQ-027 At most one grant bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-028 Reset high SHALL immediately force state IDLE, ptr=0, and grant, done, timeout, busy, transmitEnable, load and parallelDataOut all to 0.
REQ-029 Reset asserted mid-transfer SHALL drop transmitEnable without any done pulse; after release the block restarts from IDLE with ptr=0.

Configuration
REQ-030 Macro TX_SCHED_TIMEOUT_EN SHALL control the SEND watchdog.
REQ-031 With the macro defined: an 8-bit counter clears on SEND entry and increments each SEND cycle; on reaching TIMEOUT_CYCLES without characterSent it pulses timeout for one cycle, drops grant and transmitEnable, issues no done, advances ptr as in REQ-021, and goes to GAP.
REQ-032 With the macro undefined: SEND waits indefinitely, timeout is tied to 0, and no counter logic exists.

Verification
REQ-033 Single request: req=0001, data_in[7:0]=0x55, characterSent pulsed 170 cycles after load -> grant=0001 and load for 1 cycle, parallelDataOut=0x55, done=0001 one cycle, then GAP, then IDLE.
REQ-034 Contention: req=1111 held with ptr=0 and each send acknowledged -> grant order 0001,0010,0100,1000,0001 and exactly one done per transfer.
REQ-035 Fairness: req[0] held permanently, req[2] raised mid-transfer of requester 0 -> next grant goes to requester 2, not 0.
REQ-036 Reset in SEND: reset asserted 50 cycles into SEND -> transmitEnable=0 in the same cycle, no done pulse; after release req=0010 -> grant=0010.
REQ-037 Watchdog (macro defined, TIMEOUT_CYCLES=20): characterSent held low -> timeout pulse 20 cycles after SEND entry, grant=0, done stays 0; with the macro undefined the block is still in SEND at cycle 1000.
REQ-038 Loopback: tx_scheduler driving the transmitter/receiver pair with serial out looped to serial in, sending 0x55 then 0xAA -> received characters 0x55 then 0xAA, characterReceived once per character.
